// File: rtl/mem_writeback.sv
// Memory/writeback stage: one bus access per load/store, load alignment and extension,
// single-cycle ALU writeback, and misaligned / illegal / timeout exception pulses.
// state  | meaning
// S_IDLE | accepting ops; ALU results written back the next cycle
// S_REQ  | bus request held stable until mem_gnt
// S_WAIT | load granted, waiting for mem_rvalid
module mem_writeback #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_w_en,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_f3,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [XLEN-1:0]   wb_val,
  output logic              exc_valid,
  output logic [1:0]        exc_code
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]   mem_be_q, mem_be_d;
  logic            wb_en_q, wb_en_d, exc_valid_q, exc_valid_d;
  logic [4:0]      wb_reg_q, wb_reg_d, rd_q, rd_d;
  logic [XLEN-1:0] wb_val_q, wb_val_d;
  logic [1:0]      exc_code_q, exc_code_d;
  logic [2:0]      f3_q, f3_d;
  logic [OFFW-1:0] off_q, off_d;

  logic            f3_ok, illegal, misaligned, expired;
  logic [2:0]      align_mask;
  logic [OFFW-1:0] off;
  logic [NB-1:0]   be_base;
  logic [XLEN-1:0] st_mask, ld_sh, ld_val;
  logic [CW-1:0]   cnt_inc;

  always_comb begin
    off = ex_result[OFFW-1:0];
    f3_ok = 1'b0;
    if (ex_load) begin
      case (ex_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        3'b011, 3'b110:                         f3_ok = (XLEN == 64);
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      f3_ok = (ex_f3 == 3'b011) ? (XLEN == 64) : !ex_f3[2];
    end
    illegal = (ex_load && ex_store) || !f3_ok;

    case (ex_f3[1:0])
      2'd0:    begin align_mask = 3'b000; be_base = NB'(1);    st_mask = XLEN'(8'hFF);         end
      2'd1:    begin align_mask = 3'b001; be_base = NB'(3);    st_mask = XLEN'(16'hFFFF);      end
      2'd2:    begin align_mask = 3'b011; be_base = NB'(4'hF); st_mask = XLEN'(32'hFFFF_FFFF); end
      default: begin align_mask = 3'b111; be_base = '1;        st_mask = '1;                   end
    endcase
    misaligned = |(ex_result[2:0] & align_mask);

    // load data is extracted with the offset and size captured at accept time
    ld_sh = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_val = XLEN'($signed(ld_sh[7:0]));
      3'b001:  ld_val = XLEN'($signed(ld_sh[15:0]));
      3'b010:  ld_val = XLEN'($signed(ld_sh[31:0]));
      3'b100:  ld_val = XLEN'(ld_sh[7:0]);
      3'b101:  ld_val = XLEN'(ld_sh[15:0]);
      3'b110:  ld_val = XLEN'(ld_sh[31:0]);
      default: ld_val = ld_sh;
    endcase

    cnt_inc = cnt_q + CW'(1);
    expired = (cnt_inc == CW'(TIMEOUT));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_en_d     = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_val_d    = wb_val_q;
    exc_valid_d = 1'b0;
    exc_code_d  = exc_code_q;
    rd_d        = rd_q;
    f3_d        = f3_q;
    off_d       = off_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && ex_ready) begin
          if (!ex_load && !ex_store) begin
            wb_en_d  = ex_reg_w_en && (ex_rd != 5'd0);
            wb_reg_d = ex_rd;
            wb_val_d = ex_result;
          end else if (illegal) begin
            exc_valid_d = 1'b1;
            exc_code_d  = 2'b11;
          end else if (misaligned) begin
            exc_valid_d = 1'b1;
            exc_code_d  = 2'b01;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_store;
            mem_addr_d  = {ex_result[XLEN-1:OFFW], OFFW'(0)};
            mem_be_d    = be_base << off;
            mem_wdata_d = ex_store ? (ex_wdata & st_mask) << {off, 3'b000} : '0;
            rd_d        = ex_rd;
            f3_d        = ex_f3;
            off_d       = off;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        // a load granted on the last allowed cycle cannot finish in time
        if (mem_gnt && (mem_we_q || !expired)) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? S_IDLE : S_WAIT;
        end else if (expired) begin
          mem_req_d   = 1'b0;
          state_d     = S_IDLE;
          exc_valid_d = 1'b1;
          exc_code_d  = 2'b10;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          wb_en_d  = (rd_q != 5'd0);
          wb_reg_d = rd_q;
          wb_val_d = ld_val;
          state_d  = S_IDLE;
        end else if (expired) begin
          state_d     = S_IDLE;
          exc_valid_d = 1'b1;
          exc_code_d  = 2'b10;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_val_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      rd_q        <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_val_q    <= wb_val_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      rd_q        <= rd_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign ex_ready  = (state_q == S_IDLE) && !rst;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_reg    = wb_reg_q;
  assign wb_val    = wb_val_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback (XLEN=32, TIMEOUT=4): directed vector table, reset
// sequences, then random ops checked against an arithmetic reference model.
module tb_mem_writeback;
  localparam int XLEN = 32;
  localparam int T    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_ready, ex_reg_w_en, ex_load, ex_store;
  logic [4:0]      ex_rd, wb_reg;
  logic [2:0]      ex_f3;
  logic [XLEN-1:0] ex_result, ex_wdata, mem_addr, mem_wdata, mem_rdata, wb_val;
  logic            mem_req, mem_we, mem_gnt, mem_rvalid, wb_en, exc_valid;
  logic [3:0]      mem_be;
  logic [1:0]      exc_code;

  int total = 0;
  int bad   = 0;

  mem_writeback #(.XLEN(XLEN), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_reg_w_en(ex_reg_w_en),
    .ex_load(ex_load), .ex_store(ex_store), .ex_f3(ex_f3),
    .ex_result(ex_result), .ex_wdata(ex_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit ld, st; bit [2:0] f3; bit [4:0] rd; bit wen;
    logic [31:0] res, wdata, rdata;
    int gd, rv;
    bit [1:0] exc; bit wbe; logic [31:0] wbv, addr; logic [3:0] be; logic [31:0] wd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(bit ld, bit st, bit [2:0] f3, bit [4:0] rd, bit wen,
                              logic [31:0] res, logic [31:0] wdata, logic [31:0] rdata,
                              int gd, int rv, bit [1:0] exc, bit wbe, logic [31:0] wbv,
                              logic [31:0] addr, logic [3:0] be, logic [31:0] wd);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.rd = rd; v.wen = wen;
    v.res = res; v.wdata = wdata; v.rdata = rdata; v.gd = gd; v.rv = rv;
    v.exc = exc; v.wbe = wbe; v.wbv = wbv; v.addr = addr; v.be = be; v.wd = wd;
    return v;
  endfunction

  // Reference model: sizes, lanes and extension by plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    int sz, off;
    longint unsigned m, raw;
    o.exc = 0; o.wbe = 0; o.wbv = 0; o.addr = 0; o.be = 0; o.wd = 0;
    if (!v.ld && !v.st) begin
      o.wbe = v.wen && (v.rd != 0);
      o.wbv = v.res;
      return o;
    end
    if (v.ld && v.st) o.exc = 2'd3;
    else if (v.ld && !(v.f3 inside {0, 1, 2, 4, 5} || (XLEN == 64 && v.f3 inside {3, 6}))) o.exc = 2'd3;
    else if (v.st && !(v.f3 inside {0, 1, 2} || (XLEN == 64 && v.f3 == 3))) o.exc = 2'd3;
    if (o.exc != 0) return o;
    sz = 1 << (v.f3 % 4);
    if (v.res % sz != 0) begin
      o.exc = 2'd1;
      return o;
    end
    off    = int'(v.res % (XLEN / 8));
    o.addr = v.res - 32'(off);
    o.be   = 4'(((1 << sz) - 1) << off);
    m      = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * sz)) - 1;
    o.wd   = 32'((64'(v.wdata) & m) << (8 * off));
    raw    = (64'(v.rdata) >> (8 * off)) & m;
    if (v.f3 < 4 && raw[8 * sz - 1]) raw = raw | ~m;
    o.wbv  = 32'(raw);
    o.wbe  = v.ld && (v.rd != 0);
    return o;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_wb_en"}, wb_en, 0);
    chk({tag, "_wb_reg"}, wb_reg, 0);
    chk({tag, "_wb_val"}, wb_val, 0);
    chk({tag, "_exc_valid"}, exc_valid, 0);
    chk({tag, "_exc_code"}, exc_code, 0);
  endtask

  // Applies one op at the cycle after a posedge and follows it to completion.
  task automatic run_vec(input vec_t v);
    int g, r, k;
    bit ph, done;
    logic [31:0] lane;
    chk("ex_ready", ex_ready, 1);
    ex_valid = 1; ex_load = v.ld; ex_store = v.st; ex_f3 = v.f3; ex_rd = v.rd;
    ex_reg_w_en = v.wen; ex_result = v.res; ex_wdata = v.wdata; mem_rdata = v.rdata;
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0; ex_store = 0;
    if (v.exc != 0) begin
      chk("exc_valid", exc_valid, 1);
      chk("exc_code", exc_code, v.exc);
      chk("exc_no_req", mem_req, 0);
      chk("exc_no_wb", wb_en, 0);
      @(posedge clk); #1;
      chk("exc_pulse", exc_valid, 0);
      chk("exc_stays_idle", mem_req, 0);
    end else if (!v.ld && !v.st) begin
      chk("alu_wb_en", wb_en, v.wbe);
      chk("alu_no_exc", exc_valid, 0);
      if (v.wbe) begin
        chk("alu_wb_reg", wb_reg, v.rd);
        chk("alu_wb_val", wb_val, v.wbv);
      end
    end else begin
      for (int i = 0; i < 4; i++) lane[8*i +: 8] = v.be[i] ? 8'hFF : 8'h00;
      chk("req_asserted", mem_req, 1);
      chk("req_we", mem_we, v.st);
      chk("req_addr", mem_addr, v.addr);
      chk("req_be", mem_be, v.be);
      if (v.st) chk("req_wdata", mem_wdata & lane, v.wd);
      chk("req_no_wb", wb_en, 0);
      g = v.gd + 1;
      r = g + v.rv + 1;
      ph = 0; done = 0; k = 0;
      while (!done) begin
        k++;
        if (!ph) begin
          mem_gnt = (k == g);
          mem_rvalid = 1'($urandom_range(0, 1));
        end else begin
          mem_gnt = 1'($urandom_range(0, 1));
          mem_rvalid = (k == r);
        end
        @(posedge clk); #1;
        mem_gnt = 0; mem_rvalid = 0;
        if (v.st && k == g && g <= T) begin
          chk("st_done_req", mem_req, 0);
          chk("st_no_wb", wb_en, 0);
          chk("st_no_exc", exc_valid, 0);
          done = 1;
        end else if (v.ld && ph && k == r) begin
          chk("ld_wb_en", wb_en, v.wbe);
          if (v.wbe) begin
            chk("ld_wb_reg", wb_reg, v.rd);
            chk("ld_wb_val", wb_val, v.wbv);
          end
          chk("ld_no_exc", exc_valid, 0);
          done = 1;
        end else if (k == T) begin
          chk("tmo_exc_valid", exc_valid, 1);
          chk("tmo_exc_code", exc_code, 2);
          chk("tmo_no_wb", wb_en, 0);
          chk("tmo_req_low", mem_req, 0);
          done = 1;
        end else if (v.ld && !ph && k == g) begin
          chk("ld_gnt_req_low", mem_req, 0);
          chk("ld_gnt_no_wb", wb_en, 0);
          ph = 1;
        end else begin
          chk("wait_req", mem_req, !ph);
          chk("wait_no_exc", exc_valid, 0);
          chk("wait_no_wb", wb_en, 0);
          if (!ph) begin
            chk("hold_addr", mem_addr, v.addr);
            chk("hold_be", mem_be, v.be);
            if (v.st) chk("hold_wdata", mem_wdata & lane, v.wd);
          end
        end
      end
    end
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst = 1; ex_valid = 0; ex_load = 0; ex_store = 0; ex_f3 = 0; ex_rd = 0; ex_reg_w_en = 0;
    ex_result = 0; ex_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    //             ld st f3      rd wen res           wdata          rdata          gd rv exc wbe wbv            addr     be       wd
    tbl.push_back(mk(0, 0, 3'd0, 5, 1, 32'h1234,     0,             0,             0, 0, 0, 1, 32'h1234,      0,       4'b0000, 0));
    tbl.push_back(mk(0, 0, 3'd0, 0, 1, 32'h1234,     0,             0,             0, 0, 0, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(0, 0, 3'd0, 7, 0, 32'h55,       0,             0,             0, 0, 0, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(1, 0, 3'd0, 3, 0, 32'h103,      0,             32'h80FFFF00,  0, 0, 0, 1, 32'hFFFFFF80,  32'h100, 4'b1000, 0));
    tbl.push_back(mk(1, 0, 3'd4, 4, 0, 32'h103,      0,             32'h80FFFF00,  1, 1, 0, 1, 32'h00000080,  32'h100, 4'b1000, 0));
    tbl.push_back(mk(0, 1, 3'd1, 0, 0, 32'h202,      32'hABCD,      0,             3, 0, 0, 0, 0,             32'h200, 4'b1100, 32'hABCD0000));
    tbl.push_back(mk(1, 0, 3'd2, 6, 0, 32'h102,      0,             0,             0, 0, 1, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(1, 0, 3'd3, 6, 0, 32'h100,      0,             0,             0, 0, 3, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(1, 1, 3'd2, 6, 0, 32'h100,      0,             0,             0, 0, 3, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(1, 0, 3'd1, 8, 0, 32'h106,      0,             32'h80011234,  0, 1, 0, 1, 32'hFFFF8001,  32'h104, 4'b1100, 0));
    tbl.push_back(mk(1, 0, 3'd5, 8, 0, 32'h106,      0,             32'h80011234,  2, 0, 0, 1, 32'h00008001,  32'h104, 4'b1100, 0));
    tbl.push_back(mk(0, 1, 3'd2, 0, 0, 32'h300,      32'hDEADBEEF,  0,             1, 0, 0, 0, 0,             32'h300, 4'b1111, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 3'd0, 0, 0, 32'h301,      32'h123456AA,  0,             0, 0, 0, 0, 0,             32'h300, 4'b0010, 32'h0000AA00));
    tbl.push_back(mk(1, 0, 3'd6, 6, 0, 32'h100,      0,             0,             0, 0, 3, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(0, 1, 3'd4, 0, 0, 32'h100,      0,             0,             0, 0, 3, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(0, 1, 3'd1, 0, 0, 32'h201,      0,             0,             0, 0, 1, 0, 0,             0,       4'b0000, 0));
    tbl.push_back(mk(1, 0, 3'd2, 10, 0, 32'h400,     0,             0,             0, 9, 0, 1, 0,             32'h400, 4'b1111, 0));
    tbl.push_back(mk(0, 0, 3'd0, 12, 1, 32'hCAFE,    0,             0,             0, 0, 0, 1, 32'hCAFE,      0,       4'b0000, 0));
    tbl.push_back(mk(1, 0, 3'd2, 0, 0, 32'h404,      0,             32'h11223344,  0, 0, 0, 0, 32'h11223344,  32'h404, 4'b1111, 0));
    tbl.push_back(mk(0, 1, 3'd2, 0, 0, 32'h408,      32'h1,         0,             4, 0, 0, 0, 0,             32'h408, 4'b1111, 32'h1));
    tbl.push_back(mk(1, 0, 3'd2, 11, 0, 32'h40C,     0,             32'h5,         3, 0, 0, 1, 32'h5,         32'h40C, 4'b1111, 0));
    tbl.push_back(mk(0, 0, 3'd0, 13, 1, 32'hBEEF,    0,             0,             0, 0, 0, 1, 32'hBEEF,      0,       4'b0000, 0));

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_ready_low", ex_ready, 0);
    rst = 0;
    #1;
    chk("reset_ready_high", ex_ready, 1);

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset while waiting for load data, then a late rvalid
    chk("rw_ready", ex_ready, 1);
    ex_valid = 1; ex_load = 1; ex_f3 = 3'b010; ex_rd = 5'd9; ex_result = 32'h500;
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0;
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    chk("rw_in_wait", mem_req, 0);
    rst = 1;
    #1;
    chk("rw_ready_in_rst", ex_ready, 0);
    @(posedge clk); #1;
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    check_all_zero("rw");
    @(posedge clk); #1;
    mem_rvalid = 0;
    check_all_zero("rw_late");
    chk("rw_ready_after", ex_ready, 1);

    // reset while requesting a store, then a late grant
    ex_valid = 1; ex_store = 1; ex_f3 = 3'b010; ex_result = 32'h600; ex_wdata = 32'h77;
    @(posedge clk); #1;
    ex_valid = 0; ex_store = 0;
    chk("rr_req", mem_req, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_gnt = 1;
    check_all_zero("rr");
    @(posedge clk); #1;
    mem_gnt = 0;
    check_all_zero("rr_late");
    run_vec(mk(0, 0, 3'd0, 14, 1, 32'h4242, 0, 0, 0, 0, 0, 1, 32'h4242, 0, 4'b0000, 0));

    for (int n = 0; n < 250; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.ld = (kind >= 4 && kind < 7) || kind == 9;
      rv.st = (kind >= 7);
      rv.f3 = 3'($urandom_range(0, 7));
      rv.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rv.wen = 1'($urandom_range(0, 1));
      rv.res = $urandom;
      if ($urandom_range(0, 1) == 1) rv.res[1:0] = 2'b00;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.gd = $urandom_range(0, 4);
      rv.rv = $urandom_range(0, 3);
      run_vec(model(rv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
